// File: rtl/crypto_instr_pkg.sv
// Shared types for the crypto coprocessor: result-queue entry layout and defaults.
// Entry widths follow the package-wide XLEN/ID constants used across the coprocessor.
// No logic; imported by crypto_xif_result_queue.
package crypto_instr_pkg;

    localparam int CRYPTO_XLEN         = 64;
    localparam int CRYPTO_ID_WIDTH     = 4;
    localparam int CRYPTO_HARTID_WIDTH = 1;
    localparam int RESQ_DEFAULT_DEPTH  = 4;

    typedef enum logic [1:0] {
        RESQ_FREE   = 2'd0,
        RESQ_ISSUED = 2'd1,
        RESQ_DONE   = 2'd2
    } resq_state_e;

    typedef struct packed {
        resq_state_e                    state;
        logic                           committed;
        logic                           killed;
        logic [CRYPTO_ID_WIDTH-1:0]     id;
        logic [CRYPTO_HARTID_WIDTH-1:0] hartid;
        logic [4:0]                     rd;
        logic                           we;
        logic [CRYPTO_XLEN-1:0]         data;
    } resq_entry_t;

endpackage

// File: rtl/crypto_xif_result_queue.sv
// In-order CV-X-IF result queue: out-of-order FU write-back, commit/kill, in-order drain.
// Latency: result one cycle after later of wb/commit; 0 with CRYPTO_RESQ_BYPASS_EN (committed head + wb).
// Backpressure: result_* held stable until result_ready_i; alloc_ready_o low when full (registered count).
module crypto_xif_result_queue
    import crypto_instr_pkg::*;
#(
    parameter int Depth       = RESQ_DEFAULT_DEPTH,
    parameter int XLEN        = CRYPTO_XLEN,
    parameter int IdWidth     = CRYPTO_ID_WIDTH,
    parameter int HartIdWidth = CRYPTO_HARTID_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         alloc_valid_i,
    output logic                         alloc_ready_o,
    input  logic [IdWidth-1:0]           alloc_id_i,
    input  logic [HartIdWidth-1:0]       alloc_hartid_i,
    input  logic [4:0]                   alloc_rd_i,
    input  logic                         wb_valid_i,
    input  logic [IdWidth-1:0]           wb_id_i,
    input  logic [XLEN-1:0]              wb_data_i,
    input  logic                         wb_we_i,
    input  logic                         commit_valid_i,
    input  logic [IdWidth-1:0]           commit_id_i,
    input  logic                         commit_kill_i,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic [IdWidth-1:0]           result_id_o,
    output logic [HartIdWidth-1:0]       result_hartid_o,
    output logic [4:0]                   result_rd_o,
    output logic [XLEN-1:0]              result_data_o,
    output logic                         result_we_o,
    output logic [$clog2(Depth+1)-1:0]   occupancy_o,
    output logic                         id_err_o
);

    localparam int CntWidth = $clog2(Depth+1);
    localparam int PtrW     = $clog2(Depth);

    resq_entry_t           entries [Depth];
    logic [PtrW-1:0]       head, tail;
    logic [CntWidth-1:0]   count;
    logic                  id_err;

    logic [PtrW-1:0]       scan_idx [Depth];
    logic                  wb_found, cm_found, al_dup;
    logic [PtrW-1:0]       wb_idx, cm_idx;
    logic                  wb_hit, cm_hit, alloc_fire, pop;
    logic                  reg_valid, byp_valid;
    resq_entry_t           head_e;

    // Scan from head so the first hit is the oldest live entry with that ID.
    always_comb begin
        wb_found = 1'b0;
        wb_idx   = '0;
        cm_found = 1'b0;
        cm_idx   = '0;
        al_dup   = 1'b0;
        for (int k = 0; k < Depth; k++) begin
            scan_idx[k] = head + PtrW'(k);
            if (CntWidth'(k) < count) begin
                if (!wb_found && entries[scan_idx[k]].id == wb_id_i) begin
                    wb_found = 1'b1;
                    wb_idx   = scan_idx[k];
                end
                if (!cm_found && entries[scan_idx[k]].id == commit_id_i) begin
                    cm_found = 1'b1;
                    cm_idx   = scan_idx[k];
                end
                if (entries[scan_idx[k]].id == alloc_id_i) begin
                    al_dup = 1'b1;
                end
            end
        end
    end

    assign head_e        = entries[head];
    assign alloc_ready_o = (count != CntWidth'(Depth));
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign wb_hit        = wb_valid_i && wb_found && (entries[wb_idx].state == RESQ_ISSUED);
    assign cm_hit        = commit_valid_i && cm_found;
    assign reg_valid     = (head_e.state == RESQ_DONE) && head_e.committed && !head_e.killed;

`ifdef CRYPTO_RESQ_BYPASS_EN
    assign byp_valid = (head_e.state == RESQ_ISSUED) && head_e.committed && !head_e.killed
                       && wb_hit && (wb_idx == head);
`else
    assign byp_valid = 1'b0;
`endif

    assign result_valid_o = reg_valid || byp_valid;
    // Killed entries leave only once DONE, so a late write-back cannot hit a reused ID.
    assign pop = ((head_e.state == RESQ_DONE) && head_e.killed)
                 || (result_valid_o && result_ready_i);

    always_comb begin
        result_id_o     = '0;
        result_hartid_o = '0;
        result_rd_o     = '0;
        result_data_o   = '0;
        result_we_o     = 1'b0;
        if (result_valid_o) begin
            result_id_o     = head_e.id;
            result_hartid_o = head_e.hartid;
            result_rd_o     = head_e.rd;
            result_data_o   = byp_valid ? wb_data_i : head_e.data;
            result_we_o     = byp_valid ? wb_we_i   : head_e.we;
        end
    end

    assign occupancy_o = count;
    assign id_err_o    = id_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            id_err <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (wb_hit) begin
                entries[wb_idx].state <= RESQ_DONE;
                entries[wb_idx].data  <= wb_data_i;
                entries[wb_idx].we    <= wb_we_i;
            end
            if (cm_hit) begin
                if (commit_kill_i) entries[cm_idx].killed    <= 1'b1;
                else               entries[cm_idx].committed <= 1'b1;
            end
            if (pop) begin
                entries[head].state <= RESQ_FREE;
                head                <= head + 1'b1;
            end
            if (alloc_fire) begin
                entries[tail] <= '{state: RESQ_ISSUED, committed: 1'b0, killed: 1'b0,
                                   id: alloc_id_i, hartid: alloc_hartid_i, rd: alloc_rd_i,
                                   we: 1'b0, data: '0};
                tail          <= tail + 1'b1;
            end
            count <= count + CntWidth'(alloc_fire) - CntWidth'(pop);
            if ((wb_valid_i && !wb_hit) || (commit_valid_i && !cm_found) || (alloc_fire && al_dup)) begin
                id_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/crypto_xif_result_queue.md
Name: crypto_xif_result_queue

Overview:
- Parametrised in-order result queue for the CV-X-IF crypto coprocessor.
- It sits between the crypto scalar FU and the CV-X-IF result channel:
  - allocates one entry per accepted issue;
  - captures FU write-backs by ID, possibly out of order;
  - applies CPU commit/kill;
  - drains committed results to the core in issue order with a full valid/ready handshake.
- Replaces the unbuffered "result_valid = alu_valid" path so the coprocessor honours result backpressure and supports multiple in-flight instructions.

Parameters:
- Depth, 4, number of entries; power of 2, ≥2
- XLEN, 64, result data width
- IdWidth, 4, CV-X-IF instruction ID width
- HartIdWidth, 1, hart ID width
- CntWidth, $clog2(Depth+1), occupancy width (derived, not overridable)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- alloc_valid_i  in  1  issue accepted; allocate tail entry
- alloc_ready_o  out  1  free entry available
- alloc_id_i  in  IdWidth  instruction ID
- alloc_hartid_i  in  HartIdWidth  hart ID
- alloc_rd_i  in  5  destination register
- wb_valid_i  in  1  FU result valid
- wb_id_i  in  IdWidth  ID of result
- wb_data_i  in  XLEN  result data
- wb_we_i  in  1  result writes rd
- commit_valid_i  in  1  commit transaction
- commit_id_i  in  IdWidth  committed ID
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  head result valid
- result_ready_i  in  1  core accepts result
- result_id_o  out  IdWidth  head ID
- result_hartid_o  out  HartIdWidth  head hart ID
- result_rd_o  out  5  head rd
- result_data_o  out  XLEN  head data
- result_we_o  out  1  head we
- occupancy_o  out  CntWidth  live entries
- id_err_o  out  1  sticky protocol error flag

Behaviour:
- Reset (rst_i high at posedge): head = tail = 0, all entries FREE. Outputs after reset: occupancy_o = 0, alloc_ready_o = 1, result_valid_o = 0, id_err_o = 0, all result_* fields 0. Reset mid-operation discards every entry, with no output.
- Entry state machine: FREE → ISSUED (alloc) → DONE (wb) → FREE (pop). Orthogonal flags: committed and killed, both cleared on alloc.
- Alloc:
  - Fires when alloc_valid_i && alloc_ready_o.
  - alloc_ready_o = (occupancy_o != Depth), computed from registered count only. A pop in the same cycle does not free a slot for that cycle's alloc.
  - Tail wraps modulo Depth.
- Write-back:
  - Matches the live, non-FREE entry whose ID = wb_id_i and stores data/we; state becomes DONE.
  - No match, or a match on an entry already DONE: ignored, id_err_o set.
- Commit:
  - Matches the live entry by commit_id_i and sets killed if commit_kill_i is 1, otherwise committed.
  - No match: ignored, id_err_o set.
  - Wb and commit to the same entry in the same cycle are both applied.
- Alloc of an ID already live: entry is still allocated, id_err_o set, and matching targets the oldest live entry with that ID.
- Head drain:
  - Head is DONE && committed → result_valid_o = 1 (registered state, so one cycle after the later of wb/commit). Pop when result_ready_i = 1.
  - Head is DONE && killed → popped silently that cycle, no result_valid_o.
  - A killed entry still waits for its wb so a late FU write cannot alias a reused ID.
- Handshake: while result_valid_o && !result_ready_i, all result_* outputs are held stable, and result_valid_o never deasserts without a handshake (except on reset). result_* are zero when result_valid_o = 0.
- Throughput: one alloc, one wb, one commit and one pop per cycle; occupancy_o updates by +alloc −pop.
- Full and empty: occupancy_o = Depth deasserts alloc_ready_o. Empty queue gives result_valid_o = 0.

Optional Feature:
- Macro: CRYPTO_RESQ_BYPASS_EN.
- Defined: when the head entry is ISSUED && committed and a matching wb arrives, result_valid_o asserts combinationally in the same cycle with wb_data_i/wb_we_i (latency 0). The pop happens if result_ready_i = 1; otherwise the data is stored and held.
- Undefined: result_valid_o is derived from registered state only (latency 1 after wb).

Decomposition:
- crypto_instr_pkg gains:
  - resq_state_e (FREE, ISSUED, DONE);
  - resq_entry_t (state, committed, killed, id, hartid, rd, we, data), parametrised via the package's XLEN/ID constants;
  - RESQ_DEFAULT_DEPTH.
- No sub-module: storage, ID match (priority to oldest) and pointer logic are inline.

Test Plan:
- Alloc IDs 1, 2, 3; wb 3, 1, 2 (out of order); commit 1, 2, 3; result_ready_i = 1 → results emitted in order 1, 2, 3 with the matching data; occupancy_o returns to 0.
- Alloc ID 5, kill 5, then wb 5 → no result_valid_o; entry freed the cycle after wb; occupancy_o = 0.
- Fill Depth = 4 entries → alloc_ready_o = 0 and a 5th alloc is ignored; pop one entry → alloc_ready_o = 1 the next cycle.
- Committed head ready with result_ready_i = 0 for 5 cycles → outputs stable and valid held; ready = 1 → single pop.
- Wb ID 9 with no live entry → no state change, id_err_o = 1 and sticky until rst_i.
- Reset asserted with 3 live entries → next cycle occupancy_o = 0, result_valid_o = 0, alloc_ready_o = 1. Bypass build: committed head + wb → result_valid_o in the same cycle.
